// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between execute and writeback.
// Loads and stores go through a req/ack handshake and stall execute until the ack arrives.
module mem_access_stage #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       REG_IDX_W = 5,
  parameter int unsigned       CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] LOAD_OP   = 4'b1100,
  parameter logic [CTRL_W-1:0] STORE_OP  = 4'b1110
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_ex,
  input  logic [CTRL_W-1:0]    control_ex,
  input  logic [DATA_W-1:0]    result_ex,
  input  logic [DATA_W-1:0]    reg_data_ex,
  input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
  input  logic                 dest_reg_write_en_ex,
  output logic                 stall_ex,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 valid_ma,
  output logic [CTRL_W-1:0]    control_ma,
  output logic [DATA_W-1:0]    result_ma,
  output logic [DATA_W-1:0]    data_ma,
  output logic [REG_IDX_W-1:0] dest_reg_index_ma,
  output logic                 dest_reg_write_en_ma
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [CTRL_W-1:0]    hold_control;
  logic [DATA_W-1:0]    hold_result;
  logic [DATA_W-1:0]    hold_reg_data;
  logic [REG_IDX_W-1:0] hold_dest;
  logic                 hold_we;
  logic                 hold_store;
  logic                 is_mem_op;

  assign is_mem_op = valid_ex && ((control_ex == LOAD_OP) || (control_ex == STORE_OP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (is_mem_op) state_next = BUSY;
      BUSY:    if (mem_ack)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields come straight from the hold registers, so they stay stable for the whole wait.
  assign stall_ex  = (state == BUSY);
  assign mem_req   = (state == BUSY);
  assign mem_we    = (state == BUSY) && hold_store;
  assign mem_addr  = hold_result[ADDR_W-1:0];
  assign mem_wdata = hold_reg_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_control         <= '0;
      hold_result          <= '0;
      hold_reg_data        <= '0;
      hold_dest            <= '0;
      hold_we              <= 1'b0;
      hold_store           <= 1'b0;
      valid_ma             <= 1'b0;
      control_ma           <= '0;
      result_ma            <= '0;
      data_ma              <= '0;
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem_op) begin
            hold_control         <= control_ex;
            hold_result          <= result_ex;
            hold_reg_data        <= reg_data_ex;
            hold_dest            <= dest_reg_index_ex;
            hold_we              <= dest_reg_write_en_ex;
            hold_store           <= (control_ex == STORE_OP);
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
          end else if (valid_ex) begin
            valid_ma             <= 1'b1;
            control_ma           <= control_ex;
            result_ma            <= result_ex;
            data_ma              <= '0;
            dest_reg_index_ma    <= dest_reg_index_ex;
            dest_reg_write_en_ma <= dest_reg_write_en_ex;
          end else begin
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            valid_ma             <= 1'b1;
            control_ma           <= hold_control;
            result_ma            <= hold_result;
            data_ma              <= hold_store ? '0 : mem_rdata;
            dest_reg_index_ma    <= hold_dest;
            dest_reg_write_en_ma <= hold_we && !hold_store;
          end else begin
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
          end
        end
        default: begin
          valid_ma             <= 1'b0;
          dest_reg_write_en_ma <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Parametrised memory-access (MA) pipeline stage sitting between execute and writeback. It supersedes the fixed single-cycle MA stage. Width, register-index and opcode encodings are parameters. Memory is reached through a req/ack handshake with variable latency. While an access is outstanding the stage stalls execute and emits a bubble downstream.

Parameters:
DATA_W, 16, datapath width of result, store data and load data
ADDR_W, 16, memory address width; must satisfy ADDR_W <= DATA_W, address = result_ex[ADDR_W-1:0]
REG_IDX_W, 5, destination register index width
CTRL_W, 4, control/opcode field width
LOAD_OP, 4'b1100, control_ex encoding for load
STORE_OP, 4'b1110, control_ex encoding for store

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid_ex  in  1  execute stage presents a valid instruction
control_ex  in  CTRL_W  opcode from execute
result_ex  in  DATA_W  ALU result; address for LOAD/STORE
reg_data_ex  in  DATA_W  store data
dest_reg_index_ex  in  REG_IDX_W  destination register index
dest_reg_write_en_ex  in  1  destination write enable
stall_ex  out  1  execute must hold all *_ex inputs stable this cycle
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write (store), 0 = read (load); valid while mem_req
mem_addr  out  ADDR_W  access address; valid while mem_req
mem_wdata  out  DATA_W  store data; valid while mem_req && mem_we
mem_ack  in  1  memory completes the request this cycle
mem_rdata  in  DATA_W  load data; valid when mem_ack on a read
valid_ma  out  1  MA output registers hold a valid instruction
control_ma  out  CTRL_W  registered opcode
result_ma  out  DATA_W  registered result_ex
data_ma  out  DATA_W  registered load data (0 for non-loads)
dest_reg_index_ma  out  REG_IDX_W  registered destination index
dest_reg_write_en_ma  out  1  registered write enable, gated by valid_ma

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- On reset, all of the following are 0: every *_ma output, mem_req, mem_we, mem_addr, mem_wdata, stall_ex. FSM returns to IDLE.
- FSM has two states, IDLE and BUSY. stall_ex = (state == BUSY). mem_req = (state == BUSY).
- IDLE, valid_ex=1, control_ex neither LOAD_OP nor STORE_OP:
  - Pass-through, 1-cycle latency. Next edge loads *_ma from *_ex, with valid_ma=1 and data_ma=0.
- IDLE, valid_ex=1, control_ex==LOAD_OP or STORE_OP:
  - Next edge captures control, result, reg_data, dest index and dest write-enable into hold registers.
  - Drives mem_addr=result_ex[ADDR_W-1:0], mem_wdata=reg_data_ex, mem_we=(STORE_OP).
  - Goes to BUSY and writes a bubble to MA (valid_ma=0, dest_reg_write_en_ma=0).
- IDLE, valid_ex=0: next edge writes a bubble (valid_ma=0, dest_reg_write_en_ma=0). Other *_ma fields are don't-care but are held at their previous values.
- BUSY, mem_ack=0:
  - Request signals held stable; stall_ex=1; valid_ma=0 each cycle.
  - *_ex inputs are ignored.
- BUSY, mem_ack=1: next edge goes to IDLE and loads *_ma from the hold registers with valid_ma=1.
  - Load: data_ma=mem_rdata sampled at the ack edge; dest_reg_write_en_ma = held write enable.
  - Store: data_ma=0; dest_reg_write_en_ma forced 0.
  - mem_req deasserts in the cycle after ack.
- Latency:
  - Memory op with ack in the first BUSY cycle: valid_ma rises 2 edges after acceptance.
  - Each ack-wait cycle adds 1.
  - Back-to-back memory ops: one IDLE cycle between requests. mem_req drops for at least 1 cycle.
- Boundary cases:
  - mem_ack in IDLE is ignored.
  - Opcode match uses the full CTRL_W bits.
  - dest_reg_write_en_ma is always 0 when valid_ma=0.
- Reset mid-access: mem_req drops asynchronously and the captured request is discarded. A late mem_ack after reset release is ignored, because the FSM is in IDLE.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Assert rst_n=0 asynchronously between edges -> outputs clear immediately.
- ALU pass-through: valid_ex=1, control_ex=4'b0001, result_ex=16'h1234, dest=5'd7, we=1 -> next edge: valid_ma=1, result_ma=16'h1234, dest_reg_index_ma=7, dest_reg_write_en_ma=1, data_ma=0, stall_ex stays 0.
- Load, 3-cycle memory latency: LOAD_OP with result_ex=16'h00A0; mem_ack high in 3rd BUSY cycle with mem_rdata=16'hBEEF -> mem_req=1, mem_we=0, mem_addr=16'h00A0 for 3 cycles, stall_ex=1 for 3 cycles, then valid_ma=1 and data_ma=16'hBEEF.
- Store: STORE_OP, result_ex=16'h0010, reg_data_ex=16'h5A5A, we=1; ack in 1st BUSY cycle -> mem_we=1, mem_wdata=16'h5A5A, valid_ma=1, dest_reg_write_en_ma=0.
- Back-to-back LOAD then ALU op with ack after 2 cycles -> ALU op held via stall_ex, retires exactly 1 edge after the load's valid_ma, no duplicate or lost valid_ma.
- Reset during BUSY, then mem_ack=1 pulsed after release -> FSM in IDLE, no valid_ma, mem_req stays 0.
